// File: rtl/case_1_mul_share_pkg.sv
// Shared widths, ID width helper and result record for the case_1 multiplier arbiter.
package case_1_mul_share_pkg;
  localparam int A_W_DEF   = 12;
  localparam int B_W_DEF   = 9;
  localparam int OUT_W_DEF = 14;
  localparam int NREQ_DEF  = 4;

  // Requester index width; a 2-way arbiter still needs one bit.
  function automatic int id_width(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  localparam int ID_W_DEF = id_width(NREQ_DEF);

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [OUT_W_DEF-1:0] data;
  } res_t;
endpackage

// File: rtl/case_1_rr_grant.sv
// Rotating-priority one-hot grant: search starts one past ptr and wraps.
module case_1_rr_grant
  import case_1_mul_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);
  localparam int IW1 = ID_W + 1;

  logic [NREQ-1:0] rot;
  logic [IW1-1:0]  off;
  logic [IW1-1:0]  sum;

  always_comb begin
    // Rotate so bit 0 is the highest-priority requester.
    rot = NREQ'({req, req} >> (int'(ptr) + 1));
    off = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = IW1'(k);
        any = 1'b1;
      end
    end
    sum   = IW1'(ptr) + off + IW1'(1);
    idx   = ID_W'((sum >= IW1'(NREQ)) ? (sum - IW1'(NREQ)) : sum);
    grant = '0;
    for (int i = 0; i < NREQ; i++) grant[i] = any && (idx == ID_W'(i));
  end
endmodule

// File: rtl/case_1_mul_share_arb.sv
// Round-robin sequencer time-sharing one signed A_W x B_W multiplier among NREQ requesters.
module case_1_mul_share_arb
  import case_1_mul_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int ID_W  = id_width(NREQ),
  parameter int CNT_W = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [OUT_W-1:0]    res_data,
  output logic [ID_W-1:0]     res_id,
  output logic [CNT_W-1:0]    op_count
);
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [OUT_W-1:0] data;
  } res_w_t;

  logic [NREQ-1:0]           grant;
  logic [ID_W-1:0]           g_idx;
  logic                      g_any;
  logic [ID_W-1:0]           rr_ptr;
  logic                      can_accept;
  logic                      accept;
  logic signed [A_W-1:0]     a_sel;
  logic signed [B_W-1:0]     b_sel;
  logic signed [A_W+B_W-1:0] prod;
  res_w_t                    res_d, res_q;

  case_1_rr_grant #(.NREQ(NREQ), .ID_W(ID_W)) u_grant (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (g_idx),
    .any   (g_any)
  );

  // Output register empty or draining this cycle.
  assign can_accept = !res_valid || res_ready;
  assign req_ready  = (ap_rst_n && can_accept) ? grant : '0;
  assign accept     = ap_rst_n && can_accept && g_any;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*A_W +: A_W];
        b_sel = req_b[i*B_W +: B_W];
      end
    end
    prod       = a_sel * b_sel;
    res_d.id   = g_idx;
    res_d.data = OUT_W'(prod);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      res_valid <= 1'b0;
      res_q     <= '0;
      rr_ptr    <= ID_W'(NREQ - 1);
      op_count  <= '0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_q     <= res_d;
      rr_ptr    <= g_idx;
      if (op_count != '1) op_count <= op_count + CNT_W'(1);
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign res_data = res_q.data;
  assign res_id   = res_q.id;
endmodule

// File: tb/tb_case_1_mul_share_arb.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level model.
module tb_case_1_mul_share_arb;
  localparam int NREQ = 4, A_W = 12, B_W = 9, OUT_W = 14, ID_W = 2;
  localparam int MASK = (1 << OUT_W) - 1;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*A_W-1:0] req_a = '0;
  logic [NREQ*B_W-1:0] req_b = '0;
  logic                res_ready = 1'b0;
  logic [NREQ-1:0]     req_ready, rr4;
  logic                res_valid, rv4;
  logic [OUT_W-1:0]    res_data, rd4;
  logic [ID_W-1:0]     res_id, ri4;
  logic [15:0]         op_count;
  logic [3:0]          op_count4;

  int checks = 0, failures = 0;
  int a_op[NREQ], b_op[NREQ];
  bit m_valid;
  int m_data, m_id, m_ptr, m_cnt;

  always #5 ap_clk = ~ap_clk;

  case_1_mul_share_arb #(.NREQ(NREQ), .CNT_W(16)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .op_count(op_count));

  case_1_mul_share_arb #(.NREQ(NREQ), .CNT_W(4)) dut4 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_ready(rr4),
    .req_a(req_a), .req_b(req_b), .res_valid(rv4), .res_ready(res_ready),
    .res_data(rd4), .res_id(ri4), .op_count(op_count4));

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*A_W +: A_W] = A_W'(a_op[i]);
      req_b[i*B_W +: B_W] = B_W'(b_op[i]);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = int'($urandom_range(0, 4095)) - 2048;
      b_op[i] = int'($urandom_range(0, 511)) - 256;
    end
    set_ops();
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = 0; m_id = 0; m_ptr = NREQ - 1; m_cnt = 0;
  endtask

  // Next in rotation after the last winner, among those valid; nothing while stalled or in reset.
  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    r = '0;
    if (ap_rst_n !== 1'b1 || (m_valid && !res_ready)) return r;
    for (int k = 1; k <= NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) begin
        r[(m_ptr + k) % NREQ] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_update();
    logic [NREQ-1:0] r;
    int g;
    r = exp_ready();
    g = 0;
    if (!ap_rst_n) model_reset();
    else if (r != '0) begin
      for (int i = 0; i < NREQ; i++) if (r[i]) g = i;
      m_data = (a_op[g] * b_op[g]) & MASK;
      m_id = g; m_ptr = g; m_valid = 1'b1; m_cnt++;
    end else if (res_ready) m_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge ap_clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    req_valid = 4'hF;
    rand_ops();
    repeat (2) tick();
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    checks++; if (res_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", res_data); end
    checks++; if (res_id !== '0) begin failures++; $display("FAIL reset_id got=%0d exp=0", res_id); end
    checks++; if (op_count !== '0 || op_count4 !== '0) begin failures++; $display("FAIL reset_count got=%0d/%0d exp=0", op_count, op_count4); end
    ap_rst_n = 1'b1;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    a_op[0] = 100; b_op[0] = -3;
    set_ops();
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", res_valid); end
    checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", res_id); end
    checks++; if (res_data !== 14'h3ED4) begin failures++; $display("FAIL single_data got=%h exp=3ed4", res_data); end
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", op_count); end
  endtask

  task automatic test_extremes();
    int rq[2] = '{0, 2};
    int av[2] = '{-2048, 2047};
    int bv[2] = '{-256, 255};
    logic [OUT_W-1:0] ev[2] = '{14'h0000, 14'h3701};
    for (int t = 0; t < 2; t++) begin
      req_valid = '0;
      req_valid[rq[t]] = 1'b1;
      a_op[rq[t]] = av[t]; b_op[rq[t]] = bv[t];
      set_ops();
      #1;
      checks++; if (req_ready !== req_valid) begin failures++; $display("FAIL ext_ready[%0d] got=%b exp=%b", t, req_ready, req_valid); end
      tick();
      checks++; if (res_data !== ev[t] || res_id !== ID_W'(rq[t])) begin
        failures++; $display("FAIL ext_result[%0d] got=%h/%0d exp=%h/%0d", t, res_data, res_id, ev[t], rq[t]); end
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp;
    res_ready = 1'b1;
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      #1;
      exp = NREQ'(1) << ((m_ptr + 1) % NREQ);
      checks++; if (req_ready !== exp) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, req_ready, exp); end
      tick();
      checks++; if (res_valid !== 1'b1 || res_id !== ID_W'(m_id) || res_data !== OUT_W'(m_data)) begin
        failures++; $display("FAIL rr_result[%0d] got=%b/%0d/%h exp=1/%0d/%h", c, res_valid, res_id, res_data, m_id, m_data[OUT_W-1:0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] exp;
    res_ready = 1'b0;
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      rand_ops();
      #1;
      checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready); end
      checks++; if (res_valid !== 1'b1 || res_id !== ID_W'(m_id) || res_data !== OUT_W'(m_data)) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/%0d/%h", c, res_valid, res_id, res_data, m_id, m_data[OUT_W-1:0]); end
      tick();
    end
    res_ready = 1'b1;
    #1;
    exp = NREQ'(1) << ((m_ptr + 1) % NREQ);
    checks++; if (req_ready !== exp) begin failures++; $display("FAIL bp_release_ready got=%b exp=%b", req_ready, exp); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_id !== ID_W'(m_id) || res_data !== OUT_W'(m_data) || op_count !== 16'(m_cnt)) begin
      failures++; $display("FAIL bp_release_result got=%0d/%h/%0d exp=%0d/%h/%0d", res_id, res_data, op_count, m_id, m_data[OUT_W-1:0], m_cnt); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] exp;
    for (int c = 0; c < 300; c++) begin
      req_valid = NREQ'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      #1;
      exp = exp_ready();
      checks++; if (req_ready !== exp) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, req_ready, exp); end
      checks++; if (res_valid !== m_valid || rv4 !== m_valid || res_id !== ID_W'(m_id) || res_data !== OUT_W'(m_data)) begin
        failures++; $display("FAIL rnd_out[%0d] got=%b/%0d/%h exp=%b/%0d/%h", c, res_valid, res_id, res_data, m_valid, m_id, m_data[OUT_W-1:0]); end
      checks++; if (op_count !== 16'(m_cnt) || op_count4 !== 4'(m_cnt > 15 ? 15 : m_cnt)) begin
        failures++; $display("FAIL rnd_count[%0d] got=%0d/%0d exp=%0d", c, op_count, op_count4, m_cnt); end
      tick();
    end
  endtask

  task automatic test_midreset();
    res_ready = 1'b1;
    req_valid = 4'b0010;
    rand_ops();
    tick();
    req_valid = 4'b0101;
    #1;
    ap_rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (res_valid !== 1'b0 || op_count !== '0 || op_count4 !== '0) begin
      failures++; $display("FAIL midrst_state got=%b/%0d/%0d exp=0/0/0", res_valid, op_count, op_count4); end
    checks++; if (req_ready !== 4'h0 || res_data !== '0) begin failures++; $display("FAIL midrst_ready got=%b/%h exp=0000/0", req_ready, res_data); end
    tick();
    ap_rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_first got=%b exp=0001", req_ready); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin failures++; $display("FAIL midrst_result got=%b/%0d exp=1/0", res_valid, res_id); end
    req_valid = '0;
    ap_rst_n = 1'b0;
    model_reset();
    tick();
    ap_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    res_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      req_valid = NREQ'($urandom_range(1, 15));
      rand_ops();
      tick();
      checks++; if (op_count4 !== 4'((c + 1) > 15 ? 15 : (c + 1))) begin
        failures++; $display("FAIL sat_step[%0d] got=%0d exp=%0d", c, op_count4, (c + 1) > 15 ? 15 : (c + 1)); end
    end
    checks++; if (op_count4 !== 4'hF || op_count !== 16'd20) begin failures++; $display("FAIL sat_final got=%0d/%0d exp=15/20", op_count4, op_count); end
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_round_robin();
    test_backpressure();
    test_random();
    test_midreset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
